sequence_generator: RTL
=======================

// Module: sequence_generator
// PURPOSE
//  Serial bit-stream source for the sequence-detector family: serializes a loaded pattern
//  MSB-first, one bit per clk, repeated a programmable number of times with idle gaps.
//  Drives the detector's serial input `i` in system benches. Asserts `frame` on each
//  pattern's last bit, the cycle a matching detector must flag a hit.
// PARAMETERS
//  MAX_W    8     max pattern length in bits (2..16)
//  LEN_W    4     width of len port; must hold MAX_W
//  REP_W    4     width of reps port
//  GAP_W    4     width of gap port
//  IDLE_BIT 1'b0  value on o when not emitting pattern bits
// PORTS
//  clk     in   1      single clock, all state updates on posedge
//  rst     in   1      synchronous active-high reset
//  start   in   1      request; sampled only in IDLE
//  pat     in   MAX_W  pattern; bit len-1 sent first
//  len     in   LEN_W  pattern length; 0 or >MAX_W clamps to MAX_W
//  reps    in   REP_W  frames to send; 0 treated as 1
//  gap     in   GAP_W  idle cycles between frames (0 = back-to-back)
//  o       out  1      serial bit (registered)
//  o_valid out  1      high when o carries a pattern bit
//  frame   out  1      high with last bit of each frame
//  busy    out  1      high from cycle after accepted start until done cycle inclusive
//  done    out  1      one-cycle pulse, cycle after the last bit of the last frame
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, o=IDLE_BIT, o_valid=0, frame=0, busy=0, done=0,
//    all counters 0. Applies mid-operation; a start in the same cycle as rst is ignored.
//  - States: IDLE, SHIFT, GAP, DONE.
//  - IDLE: on start=1, latch pat, len (clamped), reps (0->1), gap into shadow regs;
//    -> SHIFT. Latency: first pattern bit visible on o the cycle after start is sampled.
//  - SHIFT: o=pat_q[bit_idx], o_valid=1, bit_idx counts len-1 down to 0.
//    frame=1 when bit_idx==0. At bit_idx==0: if frames_left>1 -> GAP (gap>0) or
//    restart SHIFT (gap==0, next frame's first bit the following cycle); else -> DONE.
//  - GAP: o=IDLE_BIT, o_valid=0, exactly gap cycles, then SHIFT.
//  - DONE: o=IDLE_BIT, o_valid=0, done=1 for one cycle, busy=1 this cycle; -> IDLE.
//    start in DONE is ignored; earliest accepted start is the first IDLE cycle.
//  - start, pat, len, reps and gap changes while busy have no effect (shadowed).
//  - Counters: bit_idx LEN_W bits, frames_left REP_W bits, gap_cnt GAP_W bits; no wrap
//    (all stop at terminal value). Cycles per job = N*L + (N-1)*G + 1 (DONE) for
//    effective len L, reps N, gap G.
//  - All outputs are flops.
// TESTING
//  1. pat=8'b0000_0110, len=4, reps=1, gap=0, start 1 cycle -> o=0,1,1,0 on cycles
//     1..4, o_valid=1 on 1..4, frame only cycle 4, done cycle 5, busy cycles 1..5.
//  2. pat=3'b101, len=3, reps=3, gap=2 -> 1,0,1,_,_,1,0,1,_,_,1,0,1 (_=IDLE_BIT,
//     o_valid=0); frame on cycles 3,8,13; done cycle 14.
//  3. len=0 and len=12 with pat=8'hA5, reps=0 -> both send all 8 bits 1,0,1,0,0,1,0,1
//     once; done on cycle 9.
//  4. Start held high continuously, len=2, reps=1, gap=0 -> jobs accepted every 4
//     cycles (2 bits + DONE + IDLE); changing pat mid-job does not alter current frame.
//  5. rst=1 on 3rd bit of a 4-bit job with start=1 -> next cycle all outputs reset
//     values, state IDLE; no done pulse; a new start after rst sends full pattern.
//  6. Loopback into detector for its target pattern, reps=4, gap=0 -> detector `out`
//     rises once per frame, aligned to generator frame plus detector latency.

Source files
------------

// File: rtl/sequence_generator.sv
// ============================================================================
// | Module   : sequence_generator                                            |
// | Purpose  : Serial bit-stream source. Serializes a loaded pattern         |
// |            MSB-first (bit len-1 first), one bit per clock, repeated a    |
// |            programmable number of times with idle gaps between frames.   |
// | Ports    : clk, rst      - clock, synchronous active-high reset          |
// |            start         - job request, sampled only while idle          |
// |            pat/len/reps/gap - job description, shadowed on accept        |
// |            o, o_valid    - serial bit and its qualifier                  |
// |            frame         - high with the last bit of every frame         |
// |            busy, done    - job in progress / one-cycle completion pulse  |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
`default_nettype none

module sequence_generator #(
  parameter int   MAX_W    = 8,
  parameter int   LEN_W    = 4,
  parameter int   REP_W    = 4,
  parameter int   GAP_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAX_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             o,
  output logic             o_valid,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] C_LEN_MAX = LEN_W'(MAX_W);
  localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);
  localparam logic [REP_W-1:0] C_REP_ONE = REP_W'(1);
  localparam logic [GAP_W-1:0] C_GAP_ONE = GAP_W'(1);

  state_t           state_q;
  logic [MAX_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_idx_q;
  logic [REP_W-1:0] frames_left_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt_q;

  // Effective job parameters, loaded into the shadow registers on accept.
  logic [LEN_W-1:0] len_d;
  logic [REP_W-1:0] reps_d;

  assign len_d  = ((len == '0) || (len > C_LEN_MAX)) ? C_LEN_MAX : len;
  assign reps_d = (reps == '0) ? C_REP_ONE : reps;

  // Bit select through a shift so the index width need not match the
  // pattern's address width.
  function automatic logic pick(input logic [MAX_W-1:0] p,
                                input logic [LEN_W-1:0] idx);
    logic [MAX_W-1:0] s;
    s = p >> idx;
    return s[0];
  endfunction

  // Outputs are registered alongside the state: each transition loads the
  // output values belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pat_q         <= '0;
      len_q         <= '0;
      bit_idx_q     <= '0;
      frames_left_q <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      o             <= IDLE_BIT;
      o_valid       <= 1'b0;
      frame         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pat_q         <= pat;
            len_q         <= len_d;
            frames_left_q <= reps_d;
            gap_q         <= gap;
            bit_idx_q     <= len_d - C_LEN_ONE;
            o             <= pick(pat, len_d - C_LEN_ONE);
            o_valid       <= 1'b1;
            frame         <= (len_d == C_LEN_ONE);
            busy          <= 1'b1;
            state_q       <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (bit_idx_q != '0) begin
            bit_idx_q <= bit_idx_q - C_LEN_ONE;
            o         <= pick(pat_q, bit_idx_q - C_LEN_ONE);
            frame     <= (bit_idx_q == C_LEN_ONE);
          end else if (frames_left_q > C_REP_ONE) begin
            frames_left_q <= frames_left_q - C_REP_ONE;
            if (gap_q != '0) begin
              gap_cnt_q <= gap_q;
              o         <= IDLE_BIT;
              o_valid   <= 1'b0;
              frame     <= 1'b0;
              state_q   <= ST_GAP;
            end else begin
              // Back-to-back: next frame's first bit follows immediately.
              bit_idx_q <= len_q - C_LEN_ONE;
              o         <= pick(pat_q, len_q - C_LEN_ONE);
              frame     <= (len_q == C_LEN_ONE);
            end
          end else begin
            o       <= IDLE_BIT;
            o_valid <= 1'b0;
            frame   <= 1'b0;
            done    <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_GAP: begin
          // gap_cnt_q holds the idle cycles remaining including this one.
          if (gap_cnt_q > C_GAP_ONE) begin
            gap_cnt_q <= gap_cnt_q - C_GAP_ONE;
          end else begin
            gap_cnt_q <= '0;
            bit_idx_q <= len_q - C_LEN_ONE;
            o         <= pick(pat_q, len_q - C_LEN_ONE);
            o_valid   <= 1'b1;
            frame     <= (len_q == C_LEN_ONE);
            state_q   <= ST_SHIFT;
          end
        end

        ST_DONE: begin
          // start is deliberately not sampled here.
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
